// File: rtl/ysyx_25060170_wbu_if.sv
// Write-back unit bus bundle: EXU result handshake, load-data return channel
// and the GPR write / commit port.
interface ysyx_25060170_wbu_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;

  // EXU -> WBU result channel
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic              in_wen;
  logic              in_is_load;
  logic [F3_W-1:0]   in_funct3;
  logic [XLEN-1:0]   in_alu_result;

  // memory -> WBU load data channel
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rready;

  // register file write port and retire pulse
  logic              gpr_wen;
  logic [REG_AW-1:0] gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              commit_valid;

  // Producer side (EXU, memory and register file as seen by the driver)
  modport master (
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_alu_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, mem_rready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid
  );

  // WBU side
  modport slave (
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_alu_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, mem_rready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid
  );
endinterface

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: accepts EXU results, waits for load data when needed,
// extends it by width/sign, and drives one GPR write plus commit per instruction.
module ysyx_25060170_wbu (
  input logic                  clk,
  input logic                  rst,
  ysyx_25060170_wbu_if.slave   bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // result register
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [F3_W-1:0]   funct3_q, funct3_d;
  logic [OFF_W-1:0]  off_q, off_d;

  // registered outputs
  logic              ready_q, ready_d;
  logic              rready_q, rready_d;
  logic              commit_q, commit_d;
  logic              gwen_q, gwen_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic xfer;

  // Select the addressed byte/half and extend it according to funct3.
  function automatic logic [XLEN-1:0] load_ext(input logic [F3_W-1:0]  f3,
                                               input logic [OFF_W-1:0] off,
                                               input logic [XLEN-1:0]  word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  // A transfer uses the in_ready value the EXU actually sees this cycle.
  assign xfer = bus.in_valid && ready_q;

  // State and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      data_q   <= '0;
      funct3_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
    end
  end

  // Output registers, loaded with the decode of the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      rready_q <= 1'b0;
      commit_q <= 1'b0;
      gwen_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      ready_q  <= ready_d;
      rready_q <= rready_d;
      commit_q <= commit_d;
      gwen_q   <= gwen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state, result capture and output decode
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    ready_d  = 1'b0;
    rready_d = 1'b0;
    commit_d = 1'b0;
    gwen_d   = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;

    case (state_q)
      IDLE, WRITE: begin
        if (xfer) begin
          rd_d  = bus.in_rd;
          wen_d = bus.in_wen;
          if (bus.in_is_load) begin
            funct3_d = bus.in_funct3;
            off_d    = bus.in_alu_result[OFF_W-1:0];
            state_d  = WAIT_MEM;
          end else begin
            data_d  = bus.in_alu_result;
            state_d = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          data_d  = load_ext(funct3_q, off_q, bus.mem_rdata);
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d != WAIT_MEM);
    rready_d = (state_d == WAIT_MEM);
    if (state_d == WRITE) begin
      commit_d = 1'b1;
      gwen_d   = wen_d && (rd_d != REG_AW'(0));
      waddr_d  = rd_d;
      wdata_d  = data_d;
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.mem_rready   = rready_q;
  assign bus.commit_valid = commit_q;
  assign bus.gpr_wen      = gwen_q;
  assign bus.gpr_waddr    = waddr_q;
  assign bus.gpr_wdata    = wdata_q;

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed bench for the write-back unit: vector table of single instructions
// plus hand-written pipelining and reset sequences.
module tb_ysyx_25060170_wbu;
  logic clk;
  logic rst;

  ysyx_25060170_wbu_if bus ();

  ysyx_25060170_wbu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_gwen;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  // Compare {in_ready, mem_rready, commit_valid, gpr_wen, gpr_waddr, gpr_wdata}
  task automatic check_outs(input string name, input logic ready, input logic rready,
                            input logic commit, input logic gwen,
                            input logic [4:0] waddr, input logic [31:0] wdata);
    logic [40:0] act, exp;
    act = {bus.in_ready, bus.mem_rready, bus.commit_valid, bus.gpr_wen,
           bus.gpr_waddr, bus.gpr_wdata};
    exp = {ready, rready, commit, gwen, waddr, wdata};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b rrdy=%b commit=%b wen=%b waddr=%0d wdata=%h, expected rdy=%b rrdy=%b commit=%b wen=%b waddr=%0d wdata=%h",
               name, act[40], act[39], act[38], act[37], act[36:32], act[31:0],
               exp[40], exp[39], exp[38], exp[37], exp[36:32], exp[31:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic is_load, input logic [2:0] f3, input logic [4:0] rd,
                             input logic wen, input logic [31:0] alu);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = is_load;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
    bus.in_wen        = wen;
    bus.in_alu_result = alu;
  endtask

  initial begin
    //            load f3      rd  wen alu           rdata         exp_data      gwen
    vecs[0]  = '{1'b0, 3'b000, 5,  1, 32'h12345678, 32'h0,        32'h12345678, 1};
    vecs[1]  = '{1'b1, 3'b000, 7,  1, 32'h00001003, 32'h80FF0000, 32'hFFFFFF80, 1};
    vecs[2]  = '{1'b1, 3'b100, 7,  1, 32'h00001003, 32'h80FF0000, 32'h00000080, 1};
    vecs[3]  = '{1'b1, 3'b001, 8,  1, 32'h00002002, 32'h80017FFF, 32'hFFFF8001, 1};
    vecs[4]  = '{1'b1, 3'b101, 8,  1, 32'h00002002, 32'h80017FFF, 32'h00008001, 1};
    vecs[5]  = '{1'b0, 3'b000, 0,  1, 32'h0000DEAD, 32'h0,        32'h0000DEAD, 0};
    vecs[6]  = '{1'b1, 3'b010, 31, 1, 32'h00000100, 32'hCAFEBABE, 32'hCAFEBABE, 1};
    vecs[7]  = '{1'b1, 3'b000, 10, 1, 32'h00000000, 32'h1234567F, 32'h0000007F, 1};
    vecs[8]  = '{1'b1, 3'b000, 11, 1, 32'h00000001, 32'h00008000, 32'hFFFFFF80, 1};
    vecs[9]  = '{1'b1, 3'b001, 12, 1, 32'h00000003, 32'hFFFE0000, 32'hFFFFFFFE, 1};
    vecs[10] = '{1'b1, 3'b101, 13, 1, 32'h00000001, 32'h00019000, 32'h00009000, 1};
    vecs[11] = '{1'b1, 3'b011, 14, 1, 32'h00000002, 32'h89ABCDEF, 32'h89ABCDEF, 1};
    vecs[12] = '{1'b0, 3'b000, 9,  0, 32'h0BADF00D, 32'h0,        32'h0BADF00D, 0};

    rst               = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_rd         = '0;
    bus.in_wen        = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_funct3     = '0;
    bus.in_alu_result = '0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;

    #3;
    check_outs("reset_outputs", 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check_outs("post_reset_idle", 1, 0, 0, 0, 0, 0);

    // mem_rvalid while idle must be ignored
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55555555;
    step();
    bus.mem_rvalid = 1'b0;
    check_outs("rvalid_in_idle", 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive_instr(vecs[i].is_load, vecs[i].f3, vecs[i].rd, vecs[i].wen, vecs[i].alu);
      step();
      bus.in_valid = 1'b0;
      if (vecs[i].is_load) begin
        for (int w = 0; w < 3; w++) begin
          check_outs($sformatf("vec%0d_wait%0d", i, w), 0, 1, 0, 0, 0, 0);
          step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = vecs[i].rdata;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
      end
      check_outs($sformatf("vec%0d_write", i), 1, 0, 1, vecs[i].exp_gwen,
                 vecs[i].rd, vecs[i].exp_data);
      step();
      check_outs($sformatf("vec%0d_idle", i), 1, 0, 0, 0, 0, 0);
    end

    // three back-to-back non-loads, one write per cycle
    drive_instr(1'b0, 3'b000, 1, 1, 32'h11);
    step();
    drive_instr(1'b0, 3'b000, 2, 1, 32'h22);
    check_outs("b2b_rd1", 1, 0, 1, 1, 1, 32'h11);
    step();
    drive_instr(1'b0, 3'b000, 3, 1, 32'h33);
    check_outs("b2b_rd2", 1, 0, 1, 1, 2, 32'h22);
    step();
    bus.in_valid = 1'b0;
    check_outs("b2b_rd3", 1, 0, 1, 1, 3, 32'h33);
    step();
    check_outs("b2b_idle", 1, 0, 0, 0, 0, 0);

    // load followed by a stalled non-load
    drive_instr(1'b1, 3'b010, 4, 1, 32'h200);
    step();
    drive_instr(1'b0, 3'b000, 6, 1, 32'h66);
    check_outs("ld_nl_wait0", 0, 1, 0, 0, 0, 0);
    step();
    check_outs("ld_nl_wait1", 0, 1, 0, 0, 0, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h44;
    step();
    bus.mem_rvalid = 1'b0;
    check_outs("ld_nl_load_write", 1, 0, 1, 1, 4, 32'h44);
    step();
    bus.in_valid = 1'b0;
    check_outs("ld_nl_nonload_write", 1, 0, 1, 1, 6, 32'h66);
    step();
    check_outs("ld_nl_idle", 1, 0, 0, 0, 0, 0);

    // reset in the middle of WAIT_MEM, then a late mem_rvalid
    drive_instr(1'b1, 3'b000, 15, 1, 32'h3);
    step();
    bus.in_valid = 1'b0;
    check_outs("rst_wait_pre", 0, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_outs("rst_wait_async", 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    check_outs("rst_wait_released", 1, 0, 0, 0, 0, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    step();
    bus.mem_rvalid = 1'b0;
    check_outs("rst_wait_late_rvalid", 1, 0, 0, 0, 0, 0);
    step();
    check_outs("rst_wait_after", 1, 0, 0, 0, 0, 0);

    // reset while in WRITE drops the pending write
    drive_instr(1'b0, 3'b000, 20, 1, 32'hA5A5A5A5);
    step();
    bus.in_valid = 1'b0;
    check_outs("rst_write_pre", 1, 0, 1, 1, 20, 32'hA5A5A5A5);
    #2;
    rst = 1'b0;
    #1;
    check_outs("rst_write_async", 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    check_outs("rst_write_released", 1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_wbu.md
YSYX_25060170_WBU -- requirements
Module: ysyx_25060170_WBU

Interface
Parameters: none.
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL: in_valid  input  1  EXU result valid.
REQ-004 SHALL: in_ready  output  1  WBU can accept an EXU result this cycle.
REQ-005 SHALL: in_rd  input  5  destination register index.
REQ-006 SHALL: in_wen  input  1  instruction writes rd.
REQ-007 SHALL: in_is_load  input  1  result comes from memory, not ALU.
REQ-008 SHALL: in_funct3  input  3  load width/sign code.
REQ-009 SHALL: in_alu_result  input  32  ALU result, or load address for loads.
REQ-010 SHALL: mem_rvalid  input  1  load data valid.
REQ-011 SHALL: mem_rdata  input  32  aligned 32-bit memory word.
REQ-012 SHALL: mem_rready  output  1  WBU accepts load data this cycle.
REQ-013 SHALL: gpr_wen, gpr_waddr, gpr_wdata  output  1/5/32  drive the GPR write port.
REQ-014 SHALL: commit_valid  output  1  one-cycle pulse per retired instruction.

Function
REQ-015 SHALL: implement FSM states IDLE, WAIT_MEM, WRITE; one result register holding rd, wen, data.
REQ-016 SHALL: in_ready = 1 in IDLE and WRITE, 0 in WAIT_MEM; transfer occurs when in_valid & in_ready at the clock edge.
REQ-017 SHALL: on transfer with in_is_load=0, latch in_alu_result as data and go to WRITE.
REQ-018 SHALL: on transfer with in_is_load=1, latch rd, wen, funct3, addr[1:0] and go to WAIT_MEM.
REQ-019 SHALL: mem_rready = 1 only in WAIT_MEM; mem_rvalid in WAIT_MEM latches extended load data, next state WRITE; mem_rvalid outside WAIT_MEM is ignored.
REQ-020 SHALL: extend loads by funct3 and byte offset off=addr[1:0]:
- 000 LB: sign-extend byte mem_rdata[8*off+:8].
- 100 LBU: zero-extend the same byte.
- 001 LH: sign-extend half mem_rdata[16*off[1]+:16]; off[0] ignored.
- 101 LHU: zero-extend the same half.
- 010 and all other codes: pass the full word.
REQ-021 SHALL: in WRITE, assert commit_valid=1, gpr_waddr=latched rd, gpr_wdata=latched data, gpr_wen=latched wen && rd!=0, all for exactly that cycle.
REQ-022 SHALL: WRITE exit:
- new transfer, non-load: WRITE.
- new transfer, load: WAIT_MEM.
- no transfer: IDLE.
- sustained non-load throughput: one instruction per cycle.
REQ-023 SHALL: outside WRITE, drive gpr_wen=0, commit_valid=0, gpr_waddr=0, gpr_wdata=0.
REQ-024 SHALL: non-load latency is 1 cycle (accept at edge N, write during cycle N+1); load writes the cycle after the mem_rvalid edge.
REQ-025 SHALL: rd=0 with wen=1 still produces commit_valid but never gpr_wen.
REQ-026 SHALL: WAIT_MEM has no timeout and holds indefinitely until mem_rvalid.

Reset
REQ-027 SHALL: rst=0 forces state IDLE and clears all latched fields immediately, without waiting for clk.
REQ-028 SHALL: during reset, all outputs are 0 except in_ready=0; in_ready=1 from the first cycle after release.
REQ-029 SHALL: reset during WAIT_MEM or WRITE discards the pending instruction; a late mem_rvalid after release is ignored.

Verification
REQ-030 SHALL: non-load in_rd=5, in_wen=1, alu=0x12345678 -> next cycle gpr_wen=1, waddr=5, wdata=0x12345678, commit_valid=1.
REQ-031 SHALL: LB, addr[1:0]=3, rdata=0x80FF_0000, rd=7 -> mem_rready=1 until rvalid, then wdata=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-032 SHALL: LH with addr[1:0]=2 and rdata=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001.
REQ-033 SHALL: three back-to-back non-loads (rd=1,2,3) -> three consecutive gpr_wen cycles in order; a load then a non-load -> in_ready low during WAIT_MEM, and the non-load writes only after the load.
REQ-034 SHALL: rd=0, wen=1, alu=0xDEAD -> commit_valid=1, gpr_wen=0.
REQ-035 SHALL: assert rst mid-WAIT_MEM, release, then pulse mem_rvalid -> no gpr_wen or commit_valid, state IDLE, in_ready=1.
